// File: rtl/npu_seq_ctrl.sv
// npu_seq_ctrl
//   Sequencer for an output-stationary systolic array. A small register file
//   on a simple valid/write bus holds the buffer base addresses and the M, N
//   and K tile dimensions. Writing the start bit steps an FSM through the
//   stage sequence. Each stage drives the stage enables and the array opcode.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   cen_i, wen_i            bus access valid, write(1)/read(0)
//   addr_i, wdata_i         register byte offset, write data
//   rdata_o                 registered read data (held when not reading)
//   a_buf_on, w_buf_on      activation / weight buffer streaming enables
//   o_store_on              output store enable
//   intra_on, intra_start   intra-copy enable and first-cycle pulse
//   sa_clear, done_o        array clear pulse, end-of-run pulse
//   sa_op                   systolic array opcode
//   *_base_o, m_o, n_o      copies of the configuration registers
module npu_seq_ctrl #(
    parameter int ARRAY_DIM  = 16,
    parameter int DWIDTH     = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    localparam int MW        = $clog2(ARRAY_DIM) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cen_i,
    input  logic                  wen_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0]     wdata_i,
    output logic [DWIDTH-1:0]     rdata_o,
    output logic                  a_buf_on,
    output logic                  w_buf_on,
    output logic                  o_store_on,
    output logic                  intra_on,
    output logic                  intra_start,
    output logic                  sa_clear,
    output logic                  done_o,
    output logic [2:0]            sa_op,
    output logic [ADDR_WIDTH-1:0] a_base_o,
    output logic [ADDR_WIDTH-1:0] w_base_o,
    output logic [ADDR_WIDTH-1:0] o_base_o,
    output logic [ADDR_WIDTH-1:0] intra_o_base_o,
    output logic [ADDR_WIDTH-1:0] intra_a_base_o,
    output logic [MW-1:0]         m_o,
    output logic [MW-1:0]         n_o
);

    localparam logic [ADDR_WIDTH-1:0] OFF_CTRL    = ADDR_WIDTH'(32'h00);
    localparam logic [ADDR_WIDTH-1:0] OFF_STATUS  = ADDR_WIDTH'(32'h04);
    localparam logic [ADDR_WIDTH-1:0] OFF_A_BASE  = ADDR_WIDTH'(32'h08);
    localparam logic [ADDR_WIDTH-1:0] OFF_M       = ADDR_WIDTH'(32'h0C);
    localparam logic [ADDR_WIDTH-1:0] OFF_W_BASE  = ADDR_WIDTH'(32'h10);
    localparam logic [ADDR_WIDTH-1:0] OFF_N       = ADDR_WIDTH'(32'h14);
    localparam logic [ADDR_WIDTH-1:0] OFF_K       = ADDR_WIDTH'(32'h18);
    localparam logic [ADDR_WIDTH-1:0] OFF_O_BASE  = ADDR_WIDTH'(32'h1C);
    localparam logic [ADDR_WIDTH-1:0] OFF_INTRA_O = ADDR_WIDTH'(32'h20);
    localparam logic [ADDR_WIDTH-1:0] OFF_INTRA_A = ADDR_WIDTH'(32'h24);

    localparam logic [MW-1:0]        DIM_M   = MW'(ARRAY_DIM);
    localparam logic [CNT_WIDTH-1:0] DIM_C   = CNT_WIDTH'(ARRAY_DIM);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_FLOW, S_SKEW, S_DRAIN, S_STORE, S_CLEAR, S_DONE, S_INTRA
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;

    logic                   mode_reg;
    logic [ADDR_WIDTH-1:0]  a_base_reg, w_base_reg, o_base_reg;
    logic [ADDR_WIDTH-1:0]  intra_o_reg, intra_a_reg;
    logic [MW-1:0]          m_reg, n_reg;
    logic [CNT_WIDTH-1:0]   k_reg;
    logic                   done_reg, err_reg;
    logic [DWIDTH-1:0]      rdata_reg, read_mux;

    logic                   wr_en, rd_en, busy, status_w1c;
    logic                   start_req, params_ok, start_go, start_bad;
    logic [CNT_WIDTH-1:0]   m_c, n_c, stage_len;
    logic                   stage_last;

    assign wr_en      = cen_i && wen_i;
    assign rd_en      = cen_i && !wen_i;
    assign busy       = (state_reg != S_IDLE);
    assign status_w1c = wr_en && (addr_i == OFF_STATUS);

    // The start request is judged against the registers as they stand; the
    // mode bit comes from the same CTRL write that carries start.
    assign start_req = wr_en && (addr_i == OFF_CTRL) && wdata_i[0] && !busy;
    assign params_ok = (m_reg != '0) && (m_reg <= DIM_M) &&
                       (n_reg != '0) && (n_reg <= DIM_M) &&
                       (wdata_i[1] || (k_reg != '0));
    assign start_go  = start_req && params_ok;
    assign start_bad = start_req && !params_ok;

    assign m_c = CNT_WIDTH'(m_reg);
    assign n_c = CNT_WIDTH'(n_reg);

    // State register and shared stage counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state and stage outputs
    always_comb begin
        state_next  = state_reg;
        stage_len   = CNT_ONE;
        a_buf_on    = 1'b0;
        w_buf_on    = 1'b0;
        o_store_on  = 1'b0;
        intra_on    = 1'b0;
        intra_start = 1'b0;
        sa_clear    = 1'b0;
        done_o      = 1'b0;
        sa_op       = 3'b000;
        unique case (state_reg)
            S_IDLE:  stage_len = CNT_ONE;
            S_FLOW: begin
                stage_len = k_reg;
                a_buf_on  = 1'b1;
                w_buf_on  = 1'b1;
                sa_op     = 3'b100;
            end
            S_SKEW: begin
                stage_len = m_c + n_c - CNT_ONE;
                sa_op     = 3'b100;
            end
            S_DRAIN: begin
                stage_len = DIM_C - m_c;
                sa_op     = 3'b110;
            end
            S_STORE: begin
                stage_len  = m_c + CNT_ONE;
                o_store_on = 1'b1;
            end
            S_CLEAR: sa_clear = 1'b1;
            S_DONE:  done_o   = 1'b1;
            S_INTRA: begin
                stage_len   = m_c + DIM_C - CNT_ONE;
                intra_on    = 1'b1;
                intra_start = (cnt_reg == '0);
            end
            default: stage_len = CNT_ONE;
        endcase

        stage_last = (cnt_reg == stage_len - CNT_ONE);

        unique case (state_reg)
            S_IDLE:  if (start_go) state_next = wdata_i[1] ? S_INTRA : S_FLOW;
            S_FLOW:  if (stage_last) state_next = S_SKEW;
            // A full-height tile has nothing left to drain.
            S_SKEW:  if (stage_last) state_next = (m_reg == DIM_M) ? S_STORE : S_DRAIN;
            S_DRAIN: if (stage_last) state_next = S_STORE;
            S_STORE: if (stage_last) state_next = S_CLEAR;
            S_CLEAR: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            S_INTRA: if (stage_last) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase

        cnt_next = ((state_next != state_reg) || (state_reg == S_IDLE)) ? '0 : cnt_reg + CNT_ONE;
    end

    // Read multiplexer
    always_comb begin
        read_mux = '0;
        unique case (addr_i)
            OFF_CTRL:    read_mux = DWIDTH'({mode_reg, 1'b0});
            OFF_STATUS:  read_mux = DWIDTH'({err_reg, done_reg, busy});
            OFF_A_BASE:  read_mux = DWIDTH'(a_base_reg);
            OFF_M:       read_mux = DWIDTH'(m_reg);
            OFF_W_BASE:  read_mux = DWIDTH'(w_base_reg);
            OFF_N:       read_mux = DWIDTH'(n_reg);
            OFF_K:       read_mux = DWIDTH'(k_reg);
            OFF_O_BASE:  read_mux = DWIDTH'(o_base_reg);
            OFF_INTRA_O: read_mux = DWIDTH'(intra_o_reg);
            OFF_INTRA_A: read_mux = DWIDTH'(intra_a_reg);
            default:     read_mux = '0;
        endcase
    end

    // Register file, sticky status and read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_reg    <= 1'b0;
            a_base_reg  <= '0;
            w_base_reg  <= '0;
            o_base_reg  <= '0;
            intra_o_reg <= '0;
            intra_a_reg <= '0;
            m_reg       <= '0;
            n_reg       <= '0;
            k_reg       <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            if (wr_en && !busy) begin
                unique case (addr_i)
                    OFF_CTRL:    mode_reg    <= wdata_i[1];
                    OFF_A_BASE:  a_base_reg  <= ADDR_WIDTH'(wdata_i);
                    OFF_M:       m_reg       <= MW'(wdata_i);
                    OFF_W_BASE:  w_base_reg  <= ADDR_WIDTH'(wdata_i);
                    OFF_N:       n_reg       <= MW'(wdata_i);
                    OFF_K:       k_reg       <= CNT_WIDTH'(wdata_i);
                    OFF_O_BASE:  o_base_reg  <= ADDR_WIDTH'(wdata_i);
                    OFF_INTRA_O: intra_o_reg <= ADDR_WIDTH'(wdata_i);
                    OFF_INTRA_A: intra_a_reg <= ADDR_WIDTH'(wdata_i);
                    default:     ;
                endcase
            end
            // Setting done on the DONE exit edge takes priority over a clear.
            done_reg <= (state_reg == S_DONE) || (done_reg && !(status_w1c && wdata_i[1]));
            err_reg  <= start_bad || (err_reg && !(status_w1c && wdata_i[2]));
            if (rd_en) begin
                rdata_reg <= read_mux;
            end
        end
    end

    assign rdata_o        = rdata_reg;
    assign a_base_o       = a_base_reg;
    assign w_base_o       = w_base_reg;
    assign o_base_o       = o_base_reg;
    assign intra_o_base_o = intra_o_reg;
    assign intra_a_base_o = intra_a_reg;
    assign m_o            = m_reg;
    assign n_o            = n_reg;

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// tb_npu_seq_ctrl
//   Directed and randomized runs of npu_seq_ctrl. Expected per-cycle output
//   traces are built from the stage lengths of each operation.
module tb_npu_seq_ctrl;

    localparam int DIM = 16;
    localparam int MW  = $clog2(DIM) + 1;

    logic        clk = 1'b0;
    logic        rst, cen, wen;
    logic [31:0] addr, wdata, rdata;
    logic        a_buf_on, w_buf_on, o_store_on, intra_on, intra_start, sa_clear, done_o;
    logic [2:0]  sa_op;
    logic [31:0] a_base_o, w_base_o, o_base_o, intra_o_base_o, intra_a_base_o;
    logic [MW-1:0] m_o, n_o;

    always #5 clk = ~clk;

    npu_seq_ctrl #(.ARRAY_DIM(DIM), .DWIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .wen_i(wen), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata),
        .a_buf_on(a_buf_on), .w_buf_on(w_buf_on), .o_store_on(o_store_on),
        .intra_on(intra_on), .intra_start(intra_start), .sa_clear(sa_clear),
        .done_o(done_o), .sa_op(sa_op),
        .a_base_o(a_base_o), .w_base_o(w_base_o), .o_base_o(o_base_o),
        .intra_o_base_o(intra_o_base_o), .intra_a_base_o(intra_a_base_o),
        .m_o(m_o), .n_o(n_o)
    );

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];
    logic [31:0] mdl_abase, mdl_wbase, mdl_obase, mdl_io, mdl_ia;
    logic [MW-1:0] mdl_m, mdl_n;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] outv();
        return {a_buf_on, w_buf_on, o_store_on, intra_on, intra_start, sa_clear, done_o, sa_op};
    endfunction

    function automatic logic [9:0] mk(input bit a, input bit w, input bit st, input bit io,
                                      input bit is, input bit cl, input bit dn, input logic [2:0] op);
        return {a, w, st, io, is, cl, dn, op};
    endfunction

    // Expected output trace, one entry per busy cycle.
    task automatic build(input int m, input int n, input int k, input bit mode);
        exp_q.delete();
        if (!mode) begin
            repeat (k)         exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3'b100));
            repeat (m + n - 1) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b100));
            repeat (DIM - m)   exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b110));
            repeat (m + 1)     exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3'b000));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 3'b000));
        end else begin
            for (int i = 0; i < m + DIM - 1; i++)
                exp_q.push_back(mk(0, 0, 0, 1, i == 0, 0, 0, 3'b000));
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3'b000));
    endtask

    // Bus tasks are entered and left on a falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        cen = 1'b1; wen = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cen = 1'b0; wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        cen = 1'b1; wen = 1'b0; addr = a;
        @(negedge clk);
        cen = 1'b0;
        d = rdata;
    endtask

    task automatic program_regs(input int m, input int n, input int k);
        bus_write(32'h04, 32'h6);
        mdl_abase = $urandom; mdl_wbase = $urandom; mdl_obase = $urandom;
        mdl_io = $urandom; mdl_ia = $urandom;
        mdl_m = MW'(m); mdl_n = MW'(n);
        bus_write(32'h08, mdl_abase);
        bus_write(32'h0C, m);
        bus_write(32'h10, mdl_wbase);
        bus_write(32'h14, n);
        bus_write(32'h18, k);
        bus_write(32'h1C, mdl_obase);
        bus_write(32'h20, mdl_io);
        bus_write(32'h24, mdl_ia);
        check("reg_m", m_o, mdl_m);
        check("reg_n", n_o, mdl_n);
        check("reg_abase", a_base_o, mdl_abase);
        check("reg_wbase", w_base_o, mdl_wbase);
        check("reg_obase", o_base_o, mdl_obase);
        check("reg_intra_o", intra_o_base_o, mdl_io);
        check("reg_intra_a", intra_a_base_o, mdl_ia);
    endtask

    // pokes: 0 plain, 1 bus writes while busy, 2 STATUS clear in DONE cycle.
    task automatic run_op(input string name, input int m, input int n, input int k,
                          input bit mode, input int pokes, input int rst_at);
        logic [31:0] rd;
        int len;
        program_regs(m, n, k);
        build(m, n, k, mode);
        len = exp_q.size();
        bus_write(32'h00, {30'b0, mode, 1'b1});
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s_cyc%0d", name, i), outv(), exp_q[i]);
            cen = 1'b0; wen = 1'b0;
            if (pokes != 1 && i == 2) check($sformatf("%s_status_busy", name), rdata, 32'h1);
            if (pokes == 1 && i == 5) check($sformatf("%s_abase_busy_rd", name), rdata, mdl_abase);
            if (rst_at == i) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check($sformatf("%s_rst_outs", name), outv(), 10'h0);
                check($sformatf("%s_rst_rdata", name), rdata, 32'h0);
                check($sformatf("%s_rst_abase", name), a_base_o, 32'h0);
                check($sformatf("%s_rst_m", name), m_o, '0);
                mdl_abase = '0; mdl_m = '0;
                $display("op %s m=%0d n=%0d k=%0d mode=%0d reset at cycle %0d", name, m, n, k, mode, i);
                return;
            end
            if (pokes != 1 && i == 1) begin cen = 1'b1; wen = 1'b0; addr = 32'h04; end
            if (pokes == 1 && i == 2) begin cen = 1'b1; wen = 1'b1; addr = 32'h08; wdata = 32'hDEAD_0000; end
            if (pokes == 1 && i == 3) begin cen = 1'b1; wen = 1'b1; addr = 32'h00; wdata = 32'h1; end
            if (pokes == 1 && i == 4) begin cen = 1'b1; wen = 1'b0; addr = 32'h08; end
            if (pokes == 2 && i == len - 1) begin cen = 1'b1; wen = 1'b1; addr = 32'h04; wdata = 32'h6; end
            @(negedge clk);
        end
        cen = 1'b0; wen = 1'b0;
        check($sformatf("%s_idle_after", name), outv(), 10'h0);
        bus_read(32'h04, rd);
        check($sformatf("%s_status_end", name), rd, 32'h2);
        $display("op %s m=%0d n=%0d k=%0d mode=%0d busy_cycles=%0d", name, m, n, k, mode, len);
    endtask

    initial begin
        logic [31:0] rd;
        rst = 1'b1; cen = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", outv(), 10'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_m", m_o, '0);
        check("reset_abase", a_base_o, 32'h0);
        rst = 1'b0;
        bus_read(32'h04, rd);
        check("reset_status", rd, 32'h0);

        run_op("os_4x4", 4, 4, 8, 1'b0, 0, -1);
        run_op("os_full", 16, 16, 1, 1'b0, 0, -1);
        run_op("intra_m3", 3, 4, 0, 1'b1, 0, -1);

        // Illegal parameters
        program_regs(17, 4, 8);
        bus_write(32'h00, 32'h1);
        check("bad_m_idle", outv(), 10'h0);
        bus_read(32'h04, rd);
        check("bad_m_status", rd, 32'h4);
        bus_write(32'h04, 32'h4);
        bus_read(32'h04, rd);
        check("bad_m_w1c", rd, 32'h0);
        program_regs(4, 4, 0);
        bus_write(32'h00, 32'h1);
        check("bad_k_idle", outv(), 10'h0);
        bus_read(32'h04, rd);
        check("bad_k_status", rd, 32'h4);
        $display("op illegal params checked");

        // Writes while busy are dropped; no restart and no error
        run_op("busy_wr", 4, 4, 8, 1'b0, 1, -1);
        bus_read(32'h08, rd);
        check("busy_wr_abase", rd, mdl_abase);

        // STATUS clear coinciding with DONE loses to the set
        run_op("w1c_done", 5, 3, 2, 1'b0, 2, -1);

        // Truncation of dimension registers
        bus_write(32'h0C, 32'h0000_0024);
        check("trunc_m", m_o, MW'(4));
        bus_write(32'h18, 32'h0001_0005);
        bus_read(32'h18, rd);
        check("trunc_k", rd, 32'h5);
        bus_read(32'h30, rd);
        check("unmapped_rd", rd, 32'h0);
        $display("op truncation and unmapped read checked");

        // Reset in the middle of SKEW
        run_op("rst_mid", 4, 4, 8, 1'b0, 0, 10);
        bus_read(32'h04, rd);
        check("rst_mid_status", rd, 32'h0);
        bus_read(32'h0C, rd);
        check("rst_mid_m", rd, 32'h0);
        run_op("after_rst", 4, 4, 8, 1'b0, 0, -1);

        for (int t = 0; t < 6; t++) begin
            int m, n, k;
            bit mode;
            m = $urandom_range(1, DIM);
            n = $urandom_range(1, DIM);
            k = $urandom_range(1, 12);
            mode = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", t), m, n, k, mode, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
